// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV64I multicycle control FSM (fetch/decode/execute/memory/writeback/halt)
module multicycle_control_unit (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       inst_mem_ack,
    input  logic       data_mem_ack,
    output logic       inst_mem_en,
    output logic       ir_en,
    output logic       data_mem_rd_en,
    output logic       data_mem_wr_en,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       reg_we,
    output logic [1:0] wr_reg_src,
    output logic       halted,
    output logic       illegal_instruction
);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    state_t state;
    state_t next_state;
    logic   illegal_q;
    logic   set_illegal;
    logic   known_opcode;

    always_comb begin
        known_opcode = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_FENCE, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32,
            OPC_STORE, OPC_OP, OPC_LUI, OPC_OP_32, OPC_BRANCH,
            OPC_JALR, OPC_JAL: known_opcode = 1'b1;
            default:           known_opcode = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state          = state;
        set_illegal         = 1'b0;
        inst_mem_en         = 1'b0;
        ir_en               = 1'b0;
        data_mem_rd_en      = 1'b0;
        data_mem_wr_en      = 1'b0;
        pc_en               = 1'b0;
        pc_src              = PC_PLUS4;
        alu_src_a           = 1'b0;
        alu_src_b           = 1'b0;
        reg_we              = 1'b0;
        wr_reg_src          = WB_ALU;
        halted              = 1'b0;
        illegal_instruction = 1'b0;

        // Everything is held quiet while reset is high so an aborted access never commits.
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    inst_mem_en = 1'b1;
                    if (inst_mem_ack) begin
                        ir_en      = 1'b1;
                        next_state = ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    if (known_opcode) begin
                        next_state = ST_EXECUTE;
                    end else begin
                        next_state  = ST_HALT;
                        set_illegal = (opcode != OPC_SYSTEM);
                    end
                end

                ST_EXECUTE: begin
                    case (opcode)
                        OPC_OP, OPC_OP_32: begin
                            next_state = ST_WRITEBACK;
                        end
                        OPC_OP_IMM, OPC_OP_IMM_32: begin
                            alu_src_b  = 1'b1;
                            next_state = ST_WRITEBACK;
                        end
                        OPC_AUIPC: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = 1'b1;
                            next_state = ST_WRITEBACK;
                        end
                        OPC_LUI, OPC_JAL, OPC_JALR: begin
                            next_state = ST_WRITEBACK;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            alu_src_b  = 1'b1;
                            next_state = ST_MEMORY;
                        end
                        OPC_BRANCH: begin
                            pc_en      = 1'b1;
                            pc_src     = branch_taken ? PC_IMM : PC_PLUS4;
                            next_state = ST_FETCH;
                        end
                        OPC_FENCE: begin
                            pc_en      = 1'b1;
                            pc_src     = PC_PLUS4;
                            next_state = ST_FETCH;
                        end
                        default: begin
                            next_state  = ST_HALT;
                            set_illegal = 1'b1;
                        end
                    endcase
                end

                ST_MEMORY: begin
                    alu_src_b = 1'b1;
                    if (opcode == OPC_LOAD) begin
                        data_mem_rd_en = 1'b1;
                        if (data_mem_ack) begin
                            reg_we     = 1'b1;
                            wr_reg_src = WB_MEM;
                            pc_en      = 1'b1;
                            next_state = ST_FETCH;
                        end
                    end else if (opcode == OPC_STORE) begin
                        data_mem_wr_en = 1'b1;
                        if (data_mem_ack) begin
                            pc_en      = 1'b1;
                            next_state = ST_FETCH;
                        end
                    end else begin
                        next_state  = ST_HALT;
                        set_illegal = 1'b1;
                    end
                end

                ST_WRITEBACK: begin
                    reg_we     = 1'b1;
                    pc_en      = 1'b1;
                    next_state = ST_FETCH;
                    case (opcode)
                        OPC_OP_IMM, OPC_OP_IMM_32: alu_src_b = 1'b1;
                        OPC_AUIPC: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 1'b1;
                        end
                        OPC_LUI: wr_reg_src = WB_IMM;
                        OPC_JAL: begin
                            wr_reg_src = WB_PC4;
                            pc_src     = PC_IMM;
                        end
                        OPC_JALR: begin
                            wr_reg_src = WB_PC4;
                            pc_src     = PC_JALR;
                        end
                        default: begin
                        end
                    endcase
                end

                ST_HALT: begin
                    halted              = 1'b1;
                    illegal_instruction = illegal_q;
                end

                default: begin
                    next_state = ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       inst_mem_ack;
    logic       data_mem_ack;
    logic       inst_mem_en;
    logic       ir_en;
    logic       data_mem_rd_en;
    logic       data_mem_wr_en;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       reg_we;
    logic [1:0] wr_reg_src;
    logic       halted;
    logic       illegal_instruction;

    int checks = 0;
    int errors = 0;

    multicycle_control_unit dut (
        .clock(clock), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .inst_mem_ack(inst_mem_ack), .data_mem_ack(data_mem_ack),
        .inst_mem_en(inst_mem_en), .ir_en(ir_en), .data_mem_rd_en(data_mem_rd_en),
        .data_mem_wr_en(data_mem_wr_en), .pc_en(pc_en), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_we(reg_we),
        .wr_reg_src(wr_reg_src), .halted(halted), .illegal_instruction(illegal_instruction)
    );

    always #5 clock = ~clock;

    // {ime, ir, rd, wr, pce, pcs[1:0], a, b, we, wrs[1:0], halted, illegal}
    logic [13:0] outs;
    assign outs = {inst_mem_en, ir_en, data_mem_rd_en, data_mem_wr_en, pc_en, pc_src,
                   alu_src_a, alu_src_b, reg_we, wr_reg_src, halted, illegal_instruction};

    function automatic logic [13:0] ev(input int ime, input int ir, input int rd, input int wr,
                                       input int pce, input int pcs, input int a, input int b,
                                       input int we, input int wrs, input int h, input int il);
        ev = {ime[0], ir[0], rd[0], wr[0], pce[0], pcs[1:0], a[0], b[0], we[0], wrs[1:0], h[0], il[0]};
    endfunction

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Check the current cycle's outputs away from the edge, then advance one cycle.
    task automatic cyc(input string tag, input logic [13:0] exp);
        #1;
        check(tag, outs, exp);
        @(posedge clock);
        #1;
    endtask

    localparam logic [13:0] F_ACK  = 14'b11_0000_0000_0000;
    localparam logic [13:0] F_WAIT = 14'b10_0000_0000_0000;
    localparam logic [13:0] NONE   = 14'd0;

    initial begin
        reset = 1'b1; opcode = 7'b0110011; branch_taken = 1'b0;
        inst_mem_ack = 1'b1; data_mem_ack = 1'b1;
        @(posedge clock); #1;
        cyc("reset_quiet", NONE);

        // ADD, zero-wait
        reset = 1'b0; data_mem_ack = 1'b0;
        cyc("add_fetch", F_ACK);
        cyc("add_decode", NONE);
        cyc("add_exec", NONE);
        cyc("add_wb", ev(0,0,0,0,1,0,0,0,1,0,0,0));

        // LW with three wait cycles
        opcode = 7'b0000011;
        cyc("lw_fetch", F_ACK);
        inst_mem_ack = 1'b0;
        cyc("lw_decode", NONE);
        cyc("lw_exec", ev(0,0,0,0,0,0,0,1,0,0,0,0));
        cyc("lw_mem_w0", ev(0,0,1,0,0,0,0,1,0,0,0,0));
        cyc("lw_mem_w1", ev(0,0,1,0,0,0,0,1,0,0,0,0));
        cyc("lw_mem_w2", ev(0,0,1,0,0,0,0,1,0,0,0,0));
        data_mem_ack = 1'b1;
        cyc("lw_mem_ack", ev(0,0,1,0,1,0,0,1,1,1,0,0));
        data_mem_ack = 1'b0;
        cyc("lw_next_fetch_wait", F_WAIT);

        // BEQ taken then not taken
        inst_mem_ack = 1'b1; opcode = 7'b1100011; branch_taken = 1'b1;
        cyc("beq_t_fetch", F_ACK);
        cyc("beq_t_decode", NONE);
        cyc("beq_t_exec", ev(0,0,0,0,1,1,0,0,0,0,0,0));
        branch_taken = 1'b0;
        cyc("beq_n_fetch", F_ACK);
        cyc("beq_n_decode", NONE);
        cyc("beq_n_exec", ev(0,0,0,0,1,0,0,0,0,0,0,0));

        // JAL, JALR
        opcode = 7'b1101111;
        cyc("jal_fetch", F_ACK);
        cyc("jal_decode", NONE);
        cyc("jal_exec", NONE);
        cyc("jal_wb", ev(0,0,0,0,1,1,0,0,1,2,0,0));
        opcode = 7'b1100111;
        cyc("jalr_fetch", F_ACK);
        cyc("jalr_decode", NONE);
        cyc("jalr_exec", NONE);
        cyc("jalr_wb", ev(0,0,0,0,1,2,0,0,1,2,0,0));

        // LUI, AUIPC, OP-IMM, FENCE
        opcode = 7'b0110111;
        cyc("lui_fetch", F_ACK);
        cyc("lui_decode", NONE);
        cyc("lui_exec", NONE);
        cyc("lui_wb", ev(0,0,0,0,1,0,0,0,1,3,0,0));
        opcode = 7'b0010111;
        cyc("auipc_fetch", F_ACK);
        cyc("auipc_decode", NONE);
        cyc("auipc_exec", ev(0,0,0,0,0,0,1,1,0,0,0,0));
        cyc("auipc_wb", ev(0,0,0,0,1,0,1,1,1,0,0,0));
        opcode = 7'b0010011;
        cyc("addi_fetch", F_ACK);
        cyc("addi_decode", NONE);
        cyc("addi_exec", ev(0,0,0,0,0,0,0,1,0,0,0,0));
        cyc("addi_wb", ev(0,0,0,0,1,0,0,1,1,0,0,0));
        opcode = 7'b0001111;
        cyc("fence_fetch", F_ACK);
        cyc("fence_decode", NONE);
        cyc("fence_exec", ev(0,0,0,0,1,0,0,0,0,0,0,0));

        // SW with one wait cycle
        opcode = 7'b0100011;
        cyc("sw_fetch", F_ACK);
        cyc("sw_decode", NONE);
        cyc("sw_exec", ev(0,0,0,0,0,0,0,1,0,0,0,0));
        cyc("sw_mem_w0", ev(0,0,0,1,0,0,0,1,0,0,0,0));
        data_mem_ack = 1'b1;
        cyc("sw_mem_ack", ev(0,0,0,1,1,0,0,1,0,0,0,0));

        // Illegal opcode with acks forced high
        opcode = 7'b1111111;
        cyc("ill_fetch", F_ACK);
        cyc("ill_decode", NONE);
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("ill_halt_%0d", i), ev(0,0,0,0,0,0,0,0,0,0,1,1));
        end
        reset = 1'b1;
        cyc("ill_reset", NONE);

        // ECALL halts without the illegal flag
        reset = 1'b0; opcode = 7'b1110011;
        cyc("ecall_fetch", F_ACK);
        cyc("ecall_decode", NONE);
        cyc("ecall_halt0", ev(0,0,0,0,0,0,0,0,0,0,1,0));
        cyc("ecall_halt1", ev(0,0,0,0,0,0,0,0,0,0,1,0));
        reset = 1'b1;
        cyc("ecall_reset", NONE);

        // Reset during a pending LW, then a stale data ack
        reset = 1'b0; data_mem_ack = 1'b0; opcode = 7'b0000011;
        cyc("abort_fetch", F_ACK);
        inst_mem_ack = 1'b0;
        cyc("abort_decode", NONE);
        cyc("abort_exec", ev(0,0,0,0,0,0,0,1,0,0,0,0));
        cyc("abort_mem", ev(0,0,1,0,0,0,0,1,0,0,0,0));
        reset = 1'b1; data_mem_ack = 1'b1;
        cyc("abort_rst0", NONE);
        cyc("abort_rst1", NONE);
        reset = 1'b0;
        cyc("abort_after_f0", F_WAIT);
        cyc("abort_after_f1", F_WAIT);
        inst_mem_ack = 1'b1; opcode = 7'b0110011;
        cyc("abort_add_fetch", F_ACK);
        cyc("abort_add_decode", NONE);
        cyc("abort_add_exec", NONE);
        cyc("abort_add_wb", ev(0,0,0,0,1,0,0,0,1,0,0,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle control FSM for the RV64I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the datapath enables and multiplexer selects from the registered instruction opcode, and it handshakes with separate instruction and data memory ports. It sits beside the datapath and decides which immediate path is consumed: PC target, ALU operand or writeback value.

## Interface
Parameters:
- none; the opcode encodings are the standard RV64I base opcodes.

Ports:
- clock  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces FETCH on the next edge
- opcode  in  7  instruction[6:0] taken from the instruction register (valid from DECODE onward)
- branch_taken  in  1  datapath branch comparison result, sampled in EXECUTE
- inst_mem_ack  in  1  instruction memory done; read data is valid in this cycle
- data_mem_ack  in  1  data memory done; read data is valid or the write is committed
- inst_mem_en  out  1  instruction read request
- ir_en  out  1  load the instruction register
- data_mem_rd_en  out  1  data read request
- data_mem_wr_en  out  1  data write request
- pc_en  out  1  update the PC
- pc_src  out  2  0 = pc+4, 1 = pc+imm, 2 = (rs1+imm) & ~1
- alu_src_a  out  1  0 = rs1, 1 = pc
- alu_src_b  out  1  0 = rs2, 1 = imm
- reg_we  out  1  register file write enable
- wr_reg_src  out  2  0 = ALU, 1 = memory data, 2 = pc+4, 3 = imm
- halted  out  1  core stopped
- illegal_instruction  out  1  stopped because of an unknown opcode

## Operation
States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.

Output rules:
- Outputs are combinational from state, opcode, branch_taken and the acks.
- Any output not listed for a state is 0.
- While reset is high, every output is 0.

State behaviour:
- FETCH: inst_mem_en=1 until inst_mem_ack. In the ack cycle, ir_en=1 and the next state is DECODE. Otherwise stay in FETCH.
- DECODE: one cycle for register read and immediate generation.
  - Known opcode: go to EXECUTE.
  - SYSTEM (1110011): go to HALT.
  - Any other opcode: go to HALT and set the illegal flag.
- EXECUTE, ALU selects by opcode:
  - OP (0110011) and OP-32 (0111011): a=rs1, b=rs2.
  - OP-IMM (0010011), OP-IMM-32 (0011011), LOAD (0000011), STORE (0100011): a=rs1, b=imm.
  - AUIPC (0010111): a=pc, b=imm.
- EXECUTE, next state and PC:
  - OP, OP-32, OP-IMM, OP-IMM-32, AUIPC, LUI (0110111), JAL (1101111), JALR (1100111): go to WRITEBACK.
  - LOAD, STORE: go to MEMORY.
  - BRANCH (1100011): pc_en=1, pc_src=branch_taken?1:0, go to FETCH.
  - FENCE (0001111): pc_en=1, pc_src=0, go to FETCH. FENCE is a no-op.
- MEMORY:
  - LOAD: data_mem_rd_en=1 until data_mem_ack. In the ack cycle, reg_we=1, wr_reg_src=1, pc_en=1, pc_src=0, and the next state is FETCH.
  - STORE: data_mem_wr_en=1 until data_mem_ack. In the ack cycle, pc_en=1, pc_src=0, and the next state is FETCH. reg_we stays 0.
  - alu_src_b=1 is held so the address stays stable.
- WRITEBACK: reg_we=1 and pc_en=1, then go to FETCH.
  - ALU types and AUIPC: wr_reg_src=0, pc_src=0, ALU selects held from EXECUTE.
  - LUI: wr_reg_src=3, pc_src=0.
  - JAL: wr_reg_src=2, pc_src=1.
  - JALR: wr_reg_src=2, pc_src=2.
- HALT: absorbing state, left only by reset. halted=1. illegal_instruction=1 only if HALT was entered through the illegal path. Both flags are registered and cleared by reset.

## Timing
- Reset: with reset sampled high at edge N, the state is FETCH after N. In the first cycle with reset low, inst_mem_en=1.
- Reset mid-operation aborts any pending memory request. The enables drop while reset is high and no register or PC write occurs.
- Acks may arrive in the first request cycle (zero wait) or any later cycle. An ack arriving while the matching enable is 0 is ignored.
- A request enable stays high continuously until its ack and drops in the cycle after the ack. There is never a back-to-back duplicate request for the same instruction.
- Cycles per instruction with zero-wait memory:
  - ALU, LUI, AUIPC, JAL, JALR: 4 (FETCH, DECODE, EXECUTE, WRITEBACK).
  - BRANCH, FENCE: 3.
  - LOAD, STORE: 4.
  - Each memory wait cycle adds 1.
- pc_en is asserted in exactly one cycle per retired instruction. reg_we is asserted at most once per instruction.
- opcode is assumed stable from DECODE until return to FETCH (the IR is only loaded by ir_en).

## Test plan
- Reset then ADD (0110011), zero-wait acks:
  - inst_mem_en in cycle 0, ir_en in cycle 0.
  - reg_we=1, wr_reg_src=0, pc_en=1, pc_src=0 in cycle 3.
  - inst_mem_en again in cycle 4.
- LW with data_mem_ack delayed 3 cycles:
  - data_mem_rd_en high for exactly 4 cycles.
  - reg_we, wr_reg_src=1 and pc_en all occur only in the ack cycle.
- BEQ with branch_taken=1, then with branch_taken=0:
  - EXECUTE shows pc_src=1, then pc_src=0, each with pc_en=1.
  - No reg_we at any point; the next FETCH starts in cycle 3.
- JAL and JALR:
  - WRITEBACK shows reg_we=1, wr_reg_src=2, with pc_src=1 for JAL and pc_src=2 for JALR.
  - SW: data_mem_wr_en held until ack, with reg_we never asserted.
- Opcode 1111111 decodes to HALT with halted=1 and illegal_instruction=1.
  - With acks forced high, no enable rises for 20 cycles.
  - Reset clears both flags and restarts FETCH.
  - ECALL gives halted=1 with illegal_instruction=0.
- Reset asserted during MEMORY of a pending LW:
  - All outputs go to 0 while reset is high and no reg_we fires.
  - After release: FETCH with inst_mem_en=1.
  - A stale data_mem_ack is ignored.
